// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - 64-bit synchronous data memory answering the pipeline dmem port
// Define DMEM_RANGE_CHECK_EN to reject accesses whose upper address bits are nonzero.
module data_memory_responder #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 32,
   parameter int INDEX_BITS = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] dmem_address,
   input  logic [DATA_WIDTH-1:0] dmem_dataIn,
   input  logic                  mem_enable,
   input  logic                  store_enable,
   output logic [DATA_WIDTH-1:0] dmem_dataOut,
   input  logic                  init_we,
   input  logic [INDEX_BITS-1:0] init_addr,
   input  logic [DATA_WIDTH-1:0] init_data,
   output logic [CNT_WIDTH-1:0]  load_count,
   output logic [CNT_WIDTH-1:0]  store_count,
   output logic                  addr_error
);
   localparam int DEPTH = 1 << INDEX_BITS;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [INDEX_BITS-1:0] idx;
   logic                  is_load;
   logic                  is_store;
   logic                  out_of_range;
   logic                  pipe_we;
   logic                  init_wr;
   logic [DATA_WIDTH-1:0] data_out_d, data_out_q;
   logic [CNT_WIDTH-1:0]  load_count_d, load_count_q;
   logic [CNT_WIDTH-1:0]  store_count_d, store_count_q;
   logic                  addr_error_d, addr_error_q;

   assign idx      = dmem_address[INDEX_BITS-1:0];
   assign is_load  = mem_enable && !store_enable;
   assign is_store = mem_enable && store_enable;

`ifdef DMEM_RANGE_CHECK_EN
   assign out_of_range = mem_enable && (dmem_address[ADDR_WIDTH-1:INDEX_BITS] != '0);
`else
   logic unused_upper_addr;
   assign unused_upper_addr = ^dmem_address[ADDR_WIDTH-1:INDEX_BITS];
   assign out_of_range      = 1'b0;
`endif

   always_comb begin
      data_out_d    = data_out_q;
      load_count_d  = load_count_q;
      store_count_d = store_count_q;
      addr_error_d  = out_of_range;
      // A preload to the same index overrides the pipeline store, which is still counted.
      pipe_we       = is_store && !out_of_range && !(init_we && (init_addr == idx)) && !rst;
      init_wr       = init_we && !rst;
      if (is_load) begin
         load_count_d = load_count_q + CNT_WIDTH'(1);
         data_out_d   = out_of_range ? '0 : mem_q[idx];
      end
      if (is_store) begin
         store_count_d = store_count_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (pipe_we) begin
         mem_q[idx] <= dmem_dataIn;
      end
      if (init_wr) begin
         mem_q[init_addr] <= init_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out_q    <= '0;
         load_count_q  <= '0;
         store_count_q <= '0;
         addr_error_q  <= 1'b0;
      end else begin
         data_out_q    <= data_out_d;
         load_count_q  <= load_count_d;
         store_count_q <= store_count_d;
         addr_error_q  <= addr_error_d;
      end
   end

   assign dmem_dataOut = data_out_q;
   assign load_count   = load_count_q;
   assign store_count  = store_count_q;
   assign addr_error   = addr_error_q;
endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - directed bench with a behavioural memory model for data_memory_responder
// Follows DMEM_RANGE_CHECK_EN the same way the design does.
module tb_data_memory_responder;
`ifdef DMEM_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif
   localparam logic [63:0] PAT = 64'hC0DE_0000_0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] dmem_address = '0;
   logic [63:0] dmem_dataIn = '0;
   logic        mem_enable = 1'b0;
   logic        store_enable = 1'b0;
   logic [63:0] dmem_dataOut;
   logic        init_we = 1'b0;
   logic [7:0]  init_addr = '0;
   logic [63:0] init_data = '0;
   logic [15:0] load_count;
   logic [15:0] store_count;
   logic        addr_error;

   int passed = 0;
   int total  = 0;
   bit cmp_on = 1'b0;

   logic [63:0] mdl [256];
   logic [63:0] m_dout = '0;
   logic [15:0] m_lc = '0;
   logic [15:0] m_sc = '0;
   logic        m_err = 1'b0;

   data_memory_responder dut (
      .clk(clk), .rst(rst), .dmem_address(dmem_address), .dmem_dataIn(dmem_dataIn),
      .mem_enable(mem_enable), .store_enable(store_enable), .dmem_dataOut(dmem_dataOut),
      .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
      .load_count(load_count), .store_count(store_count), .addr_error(addr_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Model: one access per cycle, loads see pre-edge contents, preload beats a colliding store.
   always @(posedge clk or posedge rst) begin
      bit          oor;
      int unsigned ix;
      if (rst) begin
         m_dout = '0; m_lc = '0; m_sc = '0; m_err = 1'b0;
      end else begin
         oor   = RC && mem_enable && ((dmem_address / 256) != 0);
         ix    = dmem_address % 256;
         m_err = oor;
         if (mem_enable && store_enable) begin
            m_sc = m_sc + 16'd1;
            if (!oor && !(init_we && int'(init_addr) == ix)) mdl[ix] = dmem_dataIn;
         end else if (mem_enable) begin
            m_lc   = m_lc + 16'd1;
            m_dout = oor ? 64'd0 : mdl[ix];
         end
         if (init_we) mdl[init_addr] = init_data;
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         chk("model_dout", dmem_dataOut, m_dout);
         chk("model_load_count", {48'd0, load_count}, {48'd0, m_lc});
         chk("model_store_count", {48'd0, store_count}, {48'd0, m_sc});
         chk("model_addr_error", {63'd0, addr_error}, {63'd0, m_err});
      end
   end

   // Drive one cycle starting just after a falling edge; returns at the next falling edge.
   task automatic cyc(input logic me, input logic se, input logic [31:0] a, input logic [63:0] d,
                      input logic iwe, input logic [7:0] ia, input logic [63:0] id);
      mem_enable = me; store_enable = se; dmem_address = a; dmem_dataIn = d;
      init_we = iwe; init_addr = ia; init_data = id;
      @(negedge clk);
      mem_enable = 1'b0; store_enable = 1'b0; init_we = 1'b0;
   endtask

   task automatic load(input logic [31:0] a);
      cyc(1'b1, 1'b0, a, 64'd0, 1'b0, 8'd0, 64'd0);
   endtask

   task automatic store(input logic [31:0] a, input logic [63:0] d);
      cyc(1'b1, 1'b1, a, d, 1'b0, 8'd0, 64'd0);
   endtask

   task automatic preload(input logic [7:0] ia, input logic [63:0] id);
      cyc(1'b0, 1'b0, 32'd0, 64'd0, 1'b1, ia, id);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mdl[i] = '0;
      // Reset held with a preload and a store presented: both must be dropped.
      init_we = 1'b1; init_addr = 8'd20; init_data = 64'hBAD;
      mem_enable = 1'b1; store_enable = 1'b1; dmem_address = 32'd21; dmem_dataIn = 64'hBAD;
      repeat (2) @(negedge clk);
      init_we = 1'b0; mem_enable = 1'b0; store_enable = 1'b0;
      chk("reset_dout", dmem_dataOut, 64'd0);
      chk("reset_load_count", {48'd0, load_count}, 64'd0);
      chk("reset_store_count", {48'd0, store_count}, 64'd0);
      chk("reset_addr_error", {63'd0, addr_error}, 64'd0);
      rst = 1'b0;
      cmp_on = 1'b1;

      for (int i = 0; i < 256; i++) preload(8'(i), PAT | 64'(i));
      chk("preload_counters_idle", {32'd0, load_count, store_count}, 64'd0);

      preload(8'd5, 64'hDEAD_BEEF_0000_0001);
      load(32'd5);
      chk("t1_dout", dmem_dataOut, 64'hDEAD_BEEF_0000_0001);
      chk("t1_load_count", {48'd0, load_count}, 64'd1);

      store(32'd7, 64'h1234);
      chk("store_holds_dout", dmem_dataOut, 64'hDEAD_BEEF_0000_0001);
      load(32'd7);
      chk("t2_dout", dmem_dataOut, 64'h1234);
      chk("t2_store_count", {48'd0, store_count}, 64'd1);

      preload(8'd3, 64'hAA);
      cyc(1'b0, 1'b1, 32'd3, 64'hBB, 1'b0, 8'd0, 64'd0);
      load(32'd3);
      chk("t3_dout", dmem_dataOut, 64'hAA);
      chk("t3_store_count", {48'd0, store_count}, 64'd1);

      cyc(1'b1, 1'b1, 32'd9, 64'h66, 1'b1, 8'd9, 64'h55);
      load(32'd9);
      chk("t4_preload_wins", dmem_dataOut, 64'h55);
      chk("t4_store_count", {48'd0, store_count}, 64'd2);

      cyc(1'b1, 1'b1, 32'd11, 64'h88, 1'b1, 8'd10, 64'h77);
      load(32'd10);
      chk("dual_write_preload", dmem_dataOut, 64'h77);
      load(32'd11);
      chk("dual_write_store", dmem_dataOut, 64'h88);

      cyc(1'b1, 1'b0, 32'd12, 64'd0, 1'b1, 8'd12, 64'h99);
      chk("preload_load_old", dmem_dataOut, 64'hC0DE_0000_0000_000C);
      load(32'd12);
      chk("preload_load_new", dmem_dataOut, 64'h99);
      cyc(1'b0, 1'b0, 32'd12, 64'd0, 1'b0, 8'd0, 64'd0);
      chk("idle_holds_dout", dmem_dataOut, 64'h99);
      load(32'd20);
      chk("reset_dropped_preload", dmem_dataOut, 64'hC0DE_0000_0000_0014);
      load(32'd21);
      chk("reset_dropped_store", dmem_dataOut, 64'hC0DE_0000_0000_0015);

      load(32'h100);
      chk("oor_load_dout", dmem_dataOut, RC ? 64'd0 : 64'hC0DE_0000_0000_0000);
      chk("oor_load_err", {63'd0, addr_error}, {63'd0, RC});
      store(32'h105, 64'hEE);
      chk("oor_store_err", {63'd0, addr_error}, {63'd0, RC});
      load(32'd5);
      chk("oor_err_clears", {63'd0, addr_error}, 64'd0);
      chk("oor_store_effect", dmem_dataOut, RC ? 64'hDEAD_BEEF_0000_0001 : 64'hEE);

      // Reset arrives after the load edge but before the outputs are sampled.
      preload(8'd40, 64'h4040);
      mem_enable = 1'b1; store_enable = 1'b0; dmem_address = 32'd40;
      @(posedge clk);
      #1 rst = 1'b1;
      mem_enable = 1'b0;
      #1;
      chk("t5_dout_cleared", dmem_dataOut, 64'd0);
      chk("t5_counts_cleared", {32'd0, load_count, store_count}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      load(32'd40);
      chk("t5_preload_survives", dmem_dataOut, 64'h4040);

      mem_enable = 1'b1; store_enable = 1'b0; dmem_address = 32'd0;
      repeat (65534) @(negedge clk);
      chk("wrap_ffff", {48'd0, load_count}, 64'hFFFF);
      @(negedge clk);
      mem_enable = 1'b0;
      chk("wrap_zero", {48'd0, load_count}, 64'd0);

      cmp_on = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
